// File: rtl/toy_controller_p.sv
// Sequencing FSM for the accumulator datapath: fetch, decode, memory read/write, execute.
// Optional HALT opcode and HALTED output are built in when CTRL_HALT_EN is defined.
module toy_controller_p #(
   parameter int OPC_W    = 4,
   parameter int MEM_WAIT = 0
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             clr_i,
   input  logic [OPC_W-1:0] opcode_i,
   input  logic             zero_i,
   output logic [2:0]       state_o,
   output logic             cl_o,
   output logic             pc_cnt_o,
   output logic             ld_ir_o,
   output logic             ld_d_o,
   output logic             ld_ac_o,
   output logic             ld_pc_o,
   output logic             cl_ac_o,
   output logic             addsub_o,
   output logic             acsel_o,
   output logic             mem_en_o,
   output logic             rorw_o,
   output logic             dorpc_o
`ifdef CTRL_HALT_EN
   ,output logic            halted_o
`endif
);

   // state  | meaning
   // RST    | clear datapath registers
   // FETCH  | read instruction at PC, load IR and bump PC on last wait cycle
   // DECODE | sample opcode/ZERO/CLR, resolve branches
   // READ   | read operand into D on last wait cycle
   // EXEC   | load AC from ALU or D
   // WRITE  | write AC to operand address
   // HALT   | parked until reset (CTRL_HALT_EN only)
   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_READ   = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WRITE  = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_SUB   = 3'd2;
   localparam logic [2:0] OP_STORE = 3'd3;
   localparam logic [2:0] OP_BZ    = 3'd4;
   localparam logic [2:0] OP_BNZ   = 3'd5;
   localparam logic [2:0] OP_LOAD  = 3'd6;
   localparam logic [2:0] OP_JMP   = 3'd7;

   localparam int WCW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);

   state_t           state_q, state_d;
   logic [WCW-1:0]   wait_q, wait_d;
   logic [2:0]       opc_q, opc_d;
   logic [2:0]       op_live;
   logic             wait_last;

   // Nonzero upper opcode bits demote the instruction to NOP.
   assign op_live   = (opcode_i[OPC_W-1:3] == '0) ? opcode_i[2:0] : OP_NOP;
   assign wait_last = (wait_q == WCW'(MEM_WAIT));
   assign state_o   = state_q;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= ST_RST;
         wait_q  <= '0;
         opc_q   <= OP_NOP;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         opc_q   <= opc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = '0;
      opc_d    = opc_q;
      cl_o     = 1'b0;
      pc_cnt_o = 1'b0;
      ld_ir_o  = 1'b0;
      ld_d_o   = 1'b0;
      ld_ac_o  = 1'b0;
      ld_pc_o  = 1'b0;
      cl_ac_o  = 1'b0;
      addsub_o = 1'b0;
      acsel_o  = 1'b0;
      mem_en_o = 1'b0;
      rorw_o   = 1'b0;
      dorpc_o  = 1'b0;
`ifdef CTRL_HALT_EN
      halted_o = 1'b0;
`endif
      case (state_q)
         ST_RST: begin
            cl_o    = 1'b1;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            mem_en_o = 1'b1;
            rorw_o   = 1'b1;
            dorpc_o  = 1'b1;
            if (wait_last) begin
               ld_ir_o  = 1'b1;
               pc_cnt_o = 1'b1;
               state_d  = ST_DECODE;
            end else begin
               wait_d = wait_q + WCW'(1);
            end
         end
         ST_DECODE: begin
            opc_d   = op_live;
            state_d = ST_FETCH;
            if (clr_i) begin
               cl_ac_o = 1'b1;
`ifdef CTRL_HALT_EN
            end else if (&opcode_i) begin
               state_d = ST_HALT;
`endif
            end else begin
               case (op_live)
                  OP_ADD, OP_SUB, OP_LOAD: state_d = ST_READ;
                  OP_STORE:                state_d = ST_WRITE;
                  OP_BZ:                   ld_pc_o = zero_i;
                  OP_BNZ:                  ld_pc_o = ~zero_i;
                  OP_JMP:                  ld_pc_o = 1'b1;
                  default:                 state_d = ST_FETCH;
               endcase
            end
         end
         ST_READ: begin
            mem_en_o = 1'b1;
            rorw_o   = 1'b1;
            if (wait_last) begin
               ld_d_o  = 1'b1;
               state_d = ST_EXEC;
            end else begin
               wait_d = wait_q + WCW'(1);
            end
         end
         ST_EXEC: begin
            ld_ac_o  = 1'b1;
            addsub_o = (opc_q == OP_SUB);
            acsel_o  = (opc_q == OP_LOAD);
            state_d  = ST_FETCH;
         end
         ST_WRITE: begin
            mem_en_o = 1'b1;
            if (wait_last) begin
               state_d = ST_FETCH;
            end else begin
               wait_d = wait_q + WCW'(1);
            end
         end
`ifdef CTRL_HALT_EN
         ST_HALT: begin
            halted_o = 1'b1;
            state_d  = ST_HALT;
         end
`endif
         default: state_d = ST_RST;
      endcase
   end

endmodule

// File: tb/tb_toy_controller_p.sv
// Scoreboard bench for toy_controller_p: two instances (MEM_WAIT 0 and 3) driven by directed
// per-instruction scripts; a negedge monitor pops expected output vectors and compares.
module tb_toy_controller_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rn   [2];
   logic       clr  [2];
   logic [3:0] opc  [2];
   logic       zero [2];
   logic [15:0] obs [2];

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      logic [2:0] st;
      logic cl, pcc, lir, ld, lac, lpc, cla, as, ax, me, rw, dp, hl;
      toy_controller_p #(.OPC_W(4), .MEM_WAIT(g == 0 ? 0 : 3)) u_dut (
         .clk_i(clk), .reset_n_i(rn[g]), .clr_i(clr[g]), .opcode_i(opc[g]), .zero_i(zero[g]),
         .state_o(st), .cl_o(cl), .pc_cnt_o(pcc), .ld_ir_o(lir), .ld_d_o(ld), .ld_ac_o(lac),
         .ld_pc_o(lpc), .cl_ac_o(cla), .addsub_o(as), .acsel_o(ax), .mem_en_o(me),
         .rorw_o(rw), .dorpc_o(dp)
`ifdef CTRL_HALT_EN
         ,.halted_o(hl)
`endif
      );
`ifndef CTRL_HALT_EN
      assign hl = 1'b0;
`endif
      assign obs[g] = {st, cl, pcc, lir, ld, lac, lpc, cla, as, ax, me, rw, dp, hl};
   end

   localparam logic [12:0] CL  = 13'h1000;
   localparam logic [12:0] PCC = 13'h0800;
   localparam logic [12:0] LIR = 13'h0400;
   localparam logic [12:0] LD  = 13'h0200;
   localparam logic [12:0] LAC = 13'h0100;
   localparam logic [12:0] LPC = 13'h0080;
   localparam logic [12:0] CLA = 13'h0040;
   localparam logic [12:0] AS  = 13'h0020;
   localparam logic [12:0] AX  = 13'h0010;
   localparam logic [12:0] ME  = 13'h0008;
   localparam logic [12:0] RW  = 13'h0004;
   localparam logic [12:0] DP  = 13'h0002;
   localparam logic [12:0] HL  = 13'h0001;
   localparam logic [12:0] NONE = 13'h0000;

   localparam logic [2:0] S_RST = 3'd0, S_FE = 3'd1, S_DE = 3'd2, S_RD = 3'd3,
                          S_EX = 3'd4, S_WR = 3'd5, S_HA = 3'd6;

   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   function automatic logic [15:0] ev(input logic [2:0] s, input logic [12:0] m);
      return {s, m};
   endfunction

   task automatic cmp(input int g, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL dut%0d_trace cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                  g, cyc_n, got[15:13], got[12:0], exp[15:13], exp[12:0]);
      end
   endtask

   always @(negedge clk) begin
      cyc_n++;
      if (q0.size() > 0) cmp(0, obs[0], q0.pop_front());
      if (q1.size() > 0) cmp(1, obs[1], q1.pop_front());
   end

   // One clock: drive inputs just after the edge and queue the vector expected for this cycle.
   task automatic cyc(input int d, input logic r, input logic c, input logic [3:0] o,
                      input logic z, input bit chk, input logic [15:0] e);
      @(posedge clk);
      #1;
      rn[d]   = r;
      clr[d]  = c;
      opc[d]  = o;
      zero[d] = z;
      if (chk) begin
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic rst_seq(input int d);
      cyc(d, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0);
      cyc(d, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, ev(S_RST, CL));
      cyc(d, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, ev(S_RST, CL));
   endtask

   // Inputs outside DECODE are driven with junk; they must be ignored.
   task automatic fetch(input int d, input int mw);
      for (int i = 0; i <= mw; i++)
         cyc(d, 1'b1, 1'b1, 4'hF, (i % 2 == 1), 1'b1,
             ev(S_FE, ME | RW | DP | ((i == mw) ? (LIR | PCC) : NONE)));
   endtask

   task automatic mem(input int d, input int mw, input logic [2:0] s,
                      input logic [12:0] m, input logic [12:0] lastm);
      for (int i = 0; i <= mw; i++)
         cyc(d, 1'b1, 1'b1, 4'hF, (i % 2 == 0), 1'b1, ev(s, m | ((i == mw) ? lastm : NONE)));
   endtask

   // path: 0 back to FETCH, 1 READ+EXEC, 2 WRITE
   task automatic run(input int d, input int mw, input logic c, input logic [3:0] o,
                      input logic z, input logic [12:0] decm, input int path,
                      input logic [12:0] exm);
      fetch(d, mw);
      cyc(d, 1'b1, c, o, z, 1'b1, ev(S_DE, decm));
      if (path == 1) begin
         mem(d, mw, S_RD, ME | RW, LD);
         cyc(d, 1'b1, 1'b1, 4'hF, ~z, 1'b1, ev(S_EX, LAC | exm));
      end else if (path == 2) begin
         mem(d, mw, S_WR, ME, NONE);
      end
   endtask

   initial begin
      for (int g = 0; g < 2; g++) begin
         rn[g] = 1'b0; clr[g] = 1'b0; opc[g] = 4'd0; zero[g] = 1'b0;
      end

      // MEM_WAIT = 0 instance
      rst_seq(0);
      run(0, 0, 1'b0, 4'd1, 1'b0, NONE, 1, NONE);   // ADD
      run(0, 0, 1'b0, 4'd2, 1'b1, NONE, 1, AS);     // SUB
      run(0, 0, 1'b0, 4'd6, 1'b0, NONE, 1, AX);     // LOAD
      run(0, 0, 1'b0, 4'd3, 1'b0, NONE, 2, NONE);   // STORE
      run(0, 0, 1'b0, 4'd4, 1'b1, LPC,  0, NONE);   // BZ taken
      run(0, 0, 1'b0, 4'd4, 1'b0, NONE, 0, NONE);   // BZ not taken
      run(0, 0, 1'b0, 4'd5, 1'b0, LPC,  0, NONE);   // BNZ taken
      run(0, 0, 1'b0, 4'd5, 1'b1, NONE, 0, NONE);   // BNZ not taken
      run(0, 0, 1'b0, 4'd7, 1'b0, LPC,  0, NONE);   // JMP
      run(0, 0, 1'b0, 4'd7, 1'b1, LPC,  0, NONE);   // JMP
      run(0, 0, 1'b1, 4'd3, 1'b0, CLA,  0, NONE);   // CLR beats STORE
      run(0, 0, 1'b0, 4'd0, 1'b1, NONE, 0, NONE);   // NOP
      run(0, 0, 1'b0, 4'd9, 1'b1, NONE, 0, NONE);   // upper bit set: NOP, not ADD
      run(0, 0, 1'b0, 4'd13, 1'b1, NONE, 0, NONE);  // upper bit set: NOP, not BNZ/BZ
      run(0, 0, 1'b0, 4'd1, 1'b0, NONE, 1, NONE);   // ADD after the NOPs
`ifdef CTRL_HALT_EN
      fetch(0, 0);
      cyc(0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, ev(S_DE, NONE));
      for (int i = 0; i < 20; i++)
         cyc(0, 1'b1, (i % 2 == 0), 4'hF, (i % 2 == 1), 1'b1, ev(S_HA, HL));
      rst_seq(0);
      run(0, 0, 1'b0, 4'd2, 1'b0, NONE, 1, AS);
`else
      run(0, 0, 1'b0, 4'hF, 1'b1, NONE, 0, NONE);   // all-ones is NOP without HALT
      run(0, 0, 1'b0, 4'd2, 1'b0, NONE, 1, AS);
`endif

      // MEM_WAIT = 3 instance
      rst_seq(1);
      run(1, 3, 1'b0, 4'd3, 1'b0, NONE, 2, NONE);   // STORE: 9 cycles
      run(1, 3, 1'b0, 4'd1, 1'b0, NONE, 1, NONE);   // ADD: 10 cycles
      run(1, 3, 1'b0, 4'd6, 1'b0, NONE, 1, AX);     // LOAD
      run(1, 3, 1'b0, 4'd4, 1'b1, LPC,  0, NONE);   // BZ: 5 cycles
      run(1, 3, 1'b1, 4'd1, 1'b0, CLA,  0, NONE);   // CLR
      // Reset during second READ cycle: abort, no LD_D
      fetch(1, 3);
      cyc(1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, ev(S_DE, NONE));
      cyc(1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, ev(S_RD, ME | RW));
      cyc(1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, ev(S_RD, ME | RW));
      cyc(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, ev(S_RST, CL));
      run(1, 3, 1'b0, 4'd2, 1'b0, NONE, 1, AS);     // SUB after recovery
      // Reset during WRITE wait
      fetch(1, 3);
      cyc(1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, ev(S_DE, NONE));
      cyc(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, ev(S_WR, ME));
      cyc(1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, ev(S_WR, ME));
      cyc(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, ev(S_RST, CL));
      run(1, 3, 1'b0, 4'd7, 1'b0, LPC, 0, NONE);

      repeat (3) @(posedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d/%0d vectors left, expected 0", q0.size(), q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/toy_controller_p.md
# toy_controller_p

Parametrised successor to the ToyProcessor controller FSM. It sequences fetch, decode, memory read, execute and memory write for the accumulator datapath. It decodes a binary opcode field from IR instead of one-hot ADD/SUB/STORE/BZ strobes. It adds LOAD, BNZ, JMP and NOP, plus configurable memory wait states. It sits between IR/ZERO flag and the PC, IR, D, AC and memory-control enables.

## Interface
Parameters:
- OPC_W, 4, opcode field width; legal 4..8.
- MEM_WAIT, 0, extra cycles every memory access is held; legal 0..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  reset, synchronous and active-low.
- CLR  in  1  request accumulator clear, sampled in DECODE.
- OPCODE  in  OPC_W  IR opcode field, sampled in DECODE only.
- ZERO  in  1  accumulator-zero flag, sampled in DECODE only.
- STATE  out  3  current state encoding (debug/bench).
- CL  out  1  clear all datapath registers.
- PC_CNT  out  1  increment PC.
- LD_IR, LD_D, LD_AC, LD_PC  out  1 each  register load enables.
- CL_AC  out  1  clear AC.
- ADDSUB  out  1  ALU op: 0 add, 1 subtract.
- ACSEL  out  1  AC input select: 0 ALU result, 1 D register (LOAD).
- MEM_EN  out  1  memory enable.
- RORW  out  1  1 read, 0 write.
- DORPC  out  1  address source: 1 PC, 0 IR operand.

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 STORE, 4 BZ, 5 BNZ, 6 LOAD, 7 JMP. Any other value executes as NOP.
- Unused upper opcode bits must be zero; otherwise the instruction is a NOP.
- States: RST=0, FETCH=1, DECODE=2, READ=3, EXEC=4, WRITE=5, HALT=6. Code 7 is unreachable; if reached, the next state is RST.
- RST: CL=1. Next state is FETCH.
- FETCH: MEM_EN=1, RORW=1, DORPC=1, held MEM_WAIT+1 cycles by the wait counter. On the final cycle only, LD_IR=1 and PC_CNT=1. Next state is DECODE.
- DECODE, when CLR=1: CL_AC=1 and next state is FETCH. CLR has priority over the opcode.
- DECODE, when CLR=0:
  - NOP goes to FETCH.
  - ADD, SUB and LOAD go to READ.
  - STORE goes to WRITE.
  - BZ asserts LD_PC=ZERO, then goes to FETCH.
  - BNZ asserts LD_PC=~ZERO, then goes to FETCH.
  - JMP asserts LD_PC=1, then goes to FETCH.
- READ: MEM_EN=1, RORW=1, DORPC=0 for MEM_WAIT+1 cycles. LD_D=1 on the final cycle. Next state is EXEC.
- EXEC: LD_AC=1. ADDSUB=1 only for SUB; ACSEL=1 only for LOAD. The opcode is latched at DECODE into an internal register, so it is not re-sampled here. Next state is FETCH.
- WRITE: MEM_EN=1, RORW=0, DORPC=0 for MEM_WAIT+1 cycles. Next state is FETCH.
- Outputs are combinational from the state register, the wait counter and the latched opcode. LD_PC and CL_AC in DECODE also depend on the live OPCODE/ZERO/CLR.
- Outputs not listed for a state are 0.
- The wait counter has width max(1, clog2(MEM_WAIT+1)). It is cleared on entry to each memory state and does not wrap; the state exits when the counter reaches MEM_WAIT.

## Timing
- With RESET_N low at an edge, the next state is RST and the wait counter and latched opcode are 0. Reset outputs: STATE=0, CL=1, all other outputs 0 (HALTED=0).
- Reset mid-operation in any state, including partway through a WRITE wait, aborts the access. MEM_EN drops the cycle after the sampling edge.
- Latency per instruction, with W=MEM_WAIT:
  - NOP, BZ, BNZ, JMP and CLR: W+2 cycles.
  - STORE: 2W+3 cycles.
  - ADD, SUB and LOAD: 2W+4 cycles.
- ZERO must be valid in DECODE, i.e. one cycle after the preceding EXEC; the AC flag path must settle within one cycle.
- Changes on CLR, OPCODE and ZERO outside DECODE have no effect.

## Configuration
- CTRL_HALT_EN defined:
  - Opcode 2^OPC_W−1 is HALT. DECODE goes to HALT and adds output HALTED (out, 1).
  - In HALT, HALTED=1 and all other outputs are 0.
  - HALT is left only via RESET_N; CLR is ignored in HALT.
- CTRL_HALT_EN undefined:
  - HALT state and HALTED port are absent.
  - Opcode 2^OPC_W−1 is a NOP.

## Test plan
- Reset: hold RESET_N=0 for 2 cycles, then release. STATE goes 0→1, with CL=1 only in the first cycle. With MEM_WAIT=0, LD_IR and PC_CNT pulse in cycle 2.
- ADD, MEM_WAIT=0: OPCODE=1. Sequence is FETCH, DECODE, READ (LD_D=1), EXEC (LD_AC=1, ADDSUB=0, ACSEL=0): 4 cycles. Repeat with SUB (ADDSUB=1) and LOAD (ACSEL=1).
- STORE, MEM_WAIT=3: OPCODE=3. WRITE holds MEM_EN=1, RORW=0, DORPC=0 for exactly 4 cycles; total 9 cycles.
- Branches: BZ with ZERO=1 gives LD_PC=1; BZ with ZERO=0 gives LD_PC=0; BNZ gives the inverse; JMP gives LD_PC=1 regardless of ZERO. Each takes 2 cycles at MEM_WAIT=0.
- CLR with OPCODE=3 in DECODE gives CL_AC=1, no WRITE entry, and next state FETCH. Opcode 9 (OPC_W=4) runs as NOP.
- RESET_N=0 in cycle 2 of a 4-cycle READ: next STATE=0, no LD_D pulse. With CTRL_HALT_EN and OPCODE=15: HALTED=1 and held for 20 cycles until reset.
